iob_vexriscv_dbus_bridge: RTL

//  Downstream of the VexRiscv core's data port: converts the VexRiscv simple dBus (cmd/rsp stream) into the
//  IOb native request/response bus feeding the system interconnect. Holds one transaction in flight.

---
 rtl/iob_vexriscv_dbus_bridge_pkg.sv | 16 +
 rtl/iob_vexriscv_timeout.sv | 37 +++
 rtl/iob_vexriscv_dbus_bridge.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/iob_vexriscv_dbus_bridge_pkg.sv
// Shared definitions for the VexRiscv dBus to IOb bridge: FSM states and dBus size codes.
package iob_vexriscv_dbus_bridge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam int SIZE_W = 2;
  localparam logic [SIZE_W-1:0] SIZE_ILLEGAL = 2'd3;

  function automatic logic size_is_illegal(input logic [SIZE_W-1:0] size);
    return size == SIZE_ILLEGAL;
  endfunction

endpackage

// File: rtl/iob_vexriscv_timeout.sv
// Wait counter for an outstanding IOb request; expire pulses on the cycle the count
// would step onto all-ones, so a request is held for exactly 2**TIMEOUT_W-1 cycles.
module iob_vexriscv_timeout #(
  parameter int TIMEOUT_W = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TIMEOUT_W-1:0] ALL_ONES   = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] LAST_COUNT = ALL_ONES - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = count_reg + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expire = enable && !clear && (count_reg == LAST_COUNT);

endmodule

// File: rtl/iob_vexriscv_dbus_bridge.sv
// Converts the VexRiscv simple dBus cmd/rsp stream into IOb native requests, one
// transaction in flight, with an error response for timed-out or illegal-size loads.
module iob_vexriscv_dbus_bridge
  import iob_vexriscv_dbus_bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dBus_cmd_valid,
  output logic                dBus_cmd_ready,
  input  logic                dBus_cmd_payload_wr,
  input  logic [ADDR_W-1:0]   dBus_cmd_payload_address,
  input  logic [DATA_W-1:0]   dBus_cmd_payload_data,
  input  logic [DATA_W/8-1:0] dBus_cmd_payload_mask,
  input  logic [SIZE_W-1:0]   dBus_cmd_payload_size,
  output logic                dBus_rsp_valid,
  output logic [DATA_W-1:0]   dBus_rsp_payload_data,
  output logic                dBus_rsp_payload_error,
  output logic                iob_valid,
  output logic [ADDR_W-1:0]   iob_addr,
  output logic [DATA_W-1:0]   iob_wdata,
  output logic [DATA_W/8-1:0] iob_wstrb,
  input  logic [DATA_W-1:0]   iob_rdata,
  input  logic                iob_ready
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
  logic                wr_reg, wr_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
  logic                rsp_error_reg, rsp_error_next;
  logic                err_pend_reg, err_pend_next;

  logic                complete;
  logic                cmd_fire;
  logic                cmd_illegal;
  logic                expire;
  logic [STRB_W-1:0]   cmd_wstrb;

  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
      assign cmd_wstrb[gi] = dBus_cmd_payload_wr & dBus_cmd_payload_mask[gi];
    end
  endgenerate

  assign complete       = (state_reg == REQ) && iob_ready;
  // A deferred error response blocks new commands for one cycle so two rsps never collide.
  assign dBus_cmd_ready = ((state_reg == IDLE) && !err_pend_reg) || complete;
  assign cmd_fire       = dBus_cmd_valid && dBus_cmd_ready;
  assign cmd_illegal    = size_is_illegal(dBus_cmd_payload_size);

  iob_vexriscv_timeout #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear ((state_reg != REQ) || iob_ready),
    .enable(state_reg == REQ),
    .expire(expire)
  );

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    wr_next        = wr_reg;
    rsp_valid_next = 1'b0;
    rsp_data_next  = '0;
    rsp_error_next = 1'b0;
    err_pend_next  = 1'b0;

    if (cmd_fire) begin
      addr_next  = dBus_cmd_payload_address;
      wdata_next = dBus_cmd_payload_data;
      wstrb_next = cmd_wstrb;
      wr_next    = dBus_cmd_payload_wr;
    end

    if (err_pend_reg) begin
      rsp_valid_next = 1'b1;
      rsp_error_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          if (!cmd_illegal) begin
            state_next = REQ;
          end else if (!dBus_cmd_payload_wr) begin
            rsp_valid_next = 1'b1;
            rsp_error_next = 1'b1;
          end
        end
      end
      REQ: begin
        if (iob_ready) begin
          state_next = IDLE;
          if (!wr_reg) begin
            rsp_valid_next = 1'b1;
            rsp_data_next  = iob_rdata;
          end
          if (cmd_fire) begin
            if (!cmd_illegal) begin
              state_next = REQ;
            end else if (!dBus_cmd_payload_wr) begin
              // Illegal load arriving alongside a completing load: its error goes out one cycle later.
              if (wr_reg) begin
                rsp_valid_next = 1'b1;
                rsp_error_next = 1'b1;
              end else begin
                err_pend_next = 1'b1;
              end
            end
          end
        end else if (expire) begin
          state_next = IDLE;
          if (!wr_reg) begin
            rsp_valid_next = 1'b1;
            rsp_error_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      wr_reg        <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_error_reg <= 1'b0;
      err_pend_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      wr_reg        <= wr_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_error_reg <= rsp_error_next;
      err_pend_reg  <= err_pend_next;
    end
  end

  assign iob_valid              = (state_reg == REQ);
  assign iob_addr               = addr_reg;
  assign iob_wdata              = wdata_reg;
  assign iob_wstrb              = wstrb_reg;
  assign dBus_rsp_valid         = rsp_valid_reg;
  assign dBus_rsp_payload_data  = rsp_data_reg;
  assign dBus_rsp_payload_error = rsp_error_reg;

endmodule
